clk_div_prog: RTL and testbench

Runtime-programmable integer clock divider with 50% duty cycle for both odd and even ratios. It is the successor to the fixed divide-by-9 OR-combined divider. Generalisations over that block:
- parametrised counter width
- ratio loaded through a shadow register with a request/ack handshake
- ratio change applied only at period boundaries, so no glitches or runt pulses
- clean start/stop via enable

Used wherever a block needs a slow derived clock whose ratio firmware can change at runtime.

---
 rtl/clk_div_pkg.sv | 20 ++
 rtl/clk_div_halfcyc.sv | 28 ++
 rtl/clk_div_prog.sv | 157 +++++++++++++++
 tb/tb_clk_div_prog.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
package clk_div_pkg;

   // Divider control states
   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StPend,
      StStop
   } state_e;

   // Smallest divisor that still yields a toggling output
   localparam int unsigned DIV_MIN = 2;

   // Number of source cycles the posedge phase flop stays high
   function automatic int unsigned half_div(input int unsigned n);
      return n >> 1;
   endfunction

endpackage

// File: rtl/clk_div_halfcyc.sv
// Negedge retime flop plus OR that stretches the high phase by half a source
// cycle for odd divisors. Only built when CLK_DIV_DUTY50_EN is defined, which
// keeps every falling-edge element of the divider inside this one module.
`ifdef CLK_DIV_DUTY50_EN
module clk_div_halfcyc (
   input  logic clk,
   input  logic rstn,
   input  logic p_r,
   input  logic odd,
   output logic clk_div
);

   logic n_r;

   // Retime the posedge phase onto the falling edge
   always_ff @(negedge clk or negedge rstn) begin
      if (!rstn) begin
         n_r <= 1'b0;
      end else begin
         n_r <= p_r;
      end
   end

   // Even divisors already have 50% duty from p_r alone
   assign clk_div = p_r | (n_r & odd);

endmodule
`endif

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider, 50% duty for even ratios and,
// when CLK_DIV_DUTY50_EN is defined, for odd ratios too. New divisors go
// through a shadow register and only take effect at period boundaries.
module clk_div_prog
   import clk_div_pkg::*;
#(
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned DIV_RST = 9
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             en,
   input  logic [CNT_W-1:0] div_val,
   input  logic             div_load,
   output logic             div_ack,
   output logic             div_err,
   output logic             period_tick,
   output logic             clk_div
);

   localparam logic [CNT_W-1:0] DivRst = CNT_W'(DIV_RST);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] act_q, act_d;
   logic [CNT_W-1:0] shd_q, shd_d;
   logic             p_q, p_d;
   logic             ack_q, ack_d;
   logic             err_q, err_d;
   logic             legal;
   logic             last;

   assign legal = div_load && (div_val >= CNT_W'(DIV_MIN));
   assign last  = (cnt_q == act_q - CNT_W'(1));

   // Next-state: counter, divisor shadowing, handshake and phase flop
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      act_d   = act_q;
      shd_d   = shd_q;
      ack_d   = 1'b0;
      err_d   = err_q;
      if (div_load) begin
         err_d = ~legal;
      end
      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (legal) begin
               act_d = div_val;
               shd_d = div_val;
               ack_d = 1'b1;
            end
            if (en) begin
               state_d = StRun;
            end
         end
         StRun: begin
            if (legal) begin
               shd_d = div_val;
            end
            if (last) begin
               cnt_d = '0;
               if (!en) begin
                  state_d = StIdle;
               end else if (legal) begin
                  state_d = StPend;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (!en) begin
                  state_d = StStop;
               end else if (legal) begin
                  state_d = StPend;
               end
            end
         end
         StPend: begin
            if (last) begin
               cnt_d = '0;
               act_d = shd_q;
               ack_d = 1'b1;
               // A load landing on the boundary waits for the next one
               if (!en) begin
                  state_d = StStop;
               end else if (legal) begin
                  state_d = StPend;
               end else begin
                  state_d = StRun;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            if (legal) begin
               shd_d = div_val;
            end
         end
         StStop: begin
            if (legal) begin
               shd_d = div_val;
            end
            if (last) begin
               cnt_d   = '0;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase
      // A divisor loaded while winding down is applied on the way into idle
      if (state_q != StIdle && state_d == StIdle && shd_d != act_d) begin
         act_d = shd_d;
         ack_d = 1'b1;
      end
      p_d = (state_d != StIdle) && (cnt_d < CNT_W'(half_div(int'(act_d))));
   end

   // State register with asynchronous active-low reset
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         act_q   <= DivRst;
         shd_q   <= DivRst;
         p_q     <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         act_q   <= act_d;
         shd_q   <= shd_d;
         p_q     <= p_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   assign div_ack     = ack_q;
   assign div_err     = err_q;
   assign period_tick = (state_q != StIdle) && last;

`ifdef CLK_DIV_DUTY50_EN
   clk_div_halfcyc u_halfcyc (
      .clk     (clk),
      .rstn    (rstn),
      .p_r     (p_q),
      .odd     (act_q[0]),
      .clk_div (clk_div)
   );
`else
   assign clk_div = p_q;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: directed test-plan steps followed by
// randomized enables and loads, compared against a period-level model.
module tb_clk_div_prog;

`ifdef CLK_DIV_DUTY50_EN
   localparam bit DUTY = 1'b1;
`else
   localparam bit DUTY = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rstn;
   logic       en;
   logic [7:0] div_val;
   logic       div_load;
   logic       div_ack;
   logic       div_err;
   logic       period_tick;
   logic       clk_div;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Model: running flag, position inside the current period, active and
   // requested divisors, pending/stopping flags, handshake outputs
   bit m_run, m_pend, m_stop, m_ack, m_err;
   int m_pos, m_n, m_sh;

   clk_div_prog #(
      .CNT_W   (8),
      .DIV_RST (9)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .en          (en),
      .div_val     (div_val),
      .div_load    (div_load),
      .div_ack     (div_ack),
      .div_err     (div_err),
      .period_tick (period_tick),
      .clk_div     (clk_div)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%0b expected=%0b", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_pend = 0; m_stop = 0; m_ack = 0; m_err = 0;
      m_pos = 0; m_n = 9; m_sh = 9;
   endtask

   // One rising edge of the source clock, using the inputs as sampled there
   task automatic model_edge();
      bit legal;
      legal = div_load && (int'(div_val) >= 2);
      m_ack = 0;
      if (!rstn) begin
         model_reset();
      end else begin
         if (div_load) m_err = !legal;
         if (!m_run) begin
            if (legal) begin m_n = int'(div_val); m_sh = m_n; m_ack = 1; end
            if (en) begin m_run = 1; m_pos = 0; m_pend = 0; m_stop = 0; end
         end else begin
            if (m_pos == m_n - 1) begin
               m_pos = 0;
               if (m_pend) begin
                  m_n = m_sh; m_ack = 1; m_pend = 0; m_stop = !en;
               end else if (m_stop || !en) begin
                  m_run = 0; m_stop = 0;
               end
            end else begin
               m_pos++;
               if (!m_pend && !en) m_stop = 1;
            end
            if (legal && m_run) begin m_sh = int'(div_val); m_pend = 1; end
         end
      end
   endtask

   // Just after a rising edge the odd-ratio extension is still visible
   task automatic check_pos();
      logic e_clk;
      e_clk = m_run && (m_pos < m_n / 2 || (DUTY && (m_n % 2 == 1) && m_pos == m_n / 2));
      check("clk_div_rise", clk_div, e_clk);
      check("period_tick", period_tick, m_run && (m_pos == m_n - 1));
      check("div_ack", div_ack, m_ack);
      check("div_err", div_err, m_err);
   endtask

   task automatic check_neg();
      check("clk_div_fall", clk_div, m_run && (m_pos < m_n / 2));
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      model_edge();
      #1;
      check_pos();
      @(negedge clk);
      #1;
      check_neg();
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic load(input int v);
      div_load = 1'b1;
      div_val  = 8'(v);
      step();
      div_load = 1'b0;
   endtask

   // Advance until the model sits at a given position of a settled period
   task automatic wait_pos(input int n_want, input int pos_want);
      int k;
      k = 0;
      while (!(m_run && !m_pend && !m_stop && m_n == n_want && m_pos == pos_want) && k < 100) begin
         step();
         k++;
      end
      checks++;
      assert (k < 100) else begin
         errors++;
         $error("FAIL wait_pos n=%0d pos=%0d not reached within 100 cycles", n_want, pos_want);
      end
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      model_reset();
      #1;
      check_pos();
      steps(2);
      rstn = 1'b1;
   endtask

   initial begin
      en       = 1'b0;
      div_load = 1'b0;
      div_val  = '0;
      model_reset();
      #2;
      do_reset();

      // Reset divisor 9 free-running
      en = 1'b1;
      steps(30);

      // Load 4 mid-period; the 9-period finishes first
      wait_pos(9, 3);
      load(4);
      steps(25);

      // Two loads inside one pending period: only 3 lands, one ack
      wait_pos(4, 1);
      load(6);
      load(3);
      steps(20);

      // Illegal load sets the sticky error, a legal one clears it
      load(1);
      steps(5);
      load(5);
      steps(25);

      // Drop enable mid-period with N = 7
      load(7);
      wait_pos(7, 2);
      en = 1'b0;
      steps(20);
      en = 1'b1;

      // Asynchronous reset while the output is high
      wait_pos(7, 0);
      do_reset();
      steps(30);

      // Randomized enables and loads
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 39) == 0) en = ~en;
         div_load = 1'b0;
         if ((!m_run || (en && !m_stop)) && $urandom_range(0, 24) == 0) begin
            div_load = 1'b1;
            div_val  = 8'($urandom_range(0, 14));
         end
         step();
      end
      div_load = 1'b0;
      steps(5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
